snake_collide: RTL and testbench
================================

// Module: snake_collide
// PURPOSE
//  Consumer of the snake block's head/body outputs. After each snake update it checks the new head box
//  against the playfield walls, each body segment and the food box. It emits grow back to the snake
//  and a sticky game_over flag, and respawns food from an LFSR. It sits between snake and game control.
// PARAMETERS
//  CW        10      coordinate width; a box is {x0,y0,x1,y1}, 4*CW bits, inclusive, x0<=x1, y0<=y1
//  NSEG      5       body segments; segment i = body[4*CW*i +: 4*CW]
//  NECK_SKIP 1       segments 0..NECK_SKIP-1 never count as collisions (neck touches head)
//  FIELD_W   640     playfield width; legal x range 0..FIELD_W-1
//  FIELD_H   480     playfield height; legal y range 0..FIELD_H-1
//  FOOD_SZ   8       food box edge length in pixels
//  FOOD_X0   320     food x0 after reset
//  FOOD_Y0   240     food y0 after reset
//  SEED      20'h1   LFSR reset value; must be nonzero
// PORTS
//  clk       in   1          system clock, rising edge
//  start_n   in   1          asynchronous active-low reset
//  update    in   1          same pulse that drives snake.update; head/body are valid on the following cycle
//  head      in   4*CW       snake head box
//  body      in   4*CW*NSEG  snake body boxes; 0 (all bits zero) = unused segment
//  grow      out  1          one-cycle pulse: head overlapped food this check
//  game_over out  1          sticky: head hit a wall or a non-neck body segment
//  done      out  1          one-cycle pulse: check complete, grow/game_over valid
//  busy      out  1          high from ARM until return to IDLE
//  food      out  4*CW       current food box
// BEHAVIOUR
//  Reset: all outputs 0 except food = {FOOD_X0, FOOD_Y0, FOOD_X0+FOOD_SZ-1, FOOD_Y0+FOOD_SZ-1}.
//   The LFSR resets to SEED and the FSM to IDLE. Reset mid-check aborts the check; no done or grow.
//  Overlap(a,b) = a.x0<=b.x1 && b.x0<=a.x1 && a.y0<=b.y1 && b.y0<=a.y1, unsigned CW-bit compares.
//  FSM, one state per cycle:
//   IDLE:    when update=1 && !game_over, go to ARM. Otherwise stay in IDLE.
//   ARM:     register head and body (busy=1).
//   WALL:    hit if x1>=FIELD_W or y1>=FIELD_H, or if x0>x1 or y0>y1 (wrapped coordinate).
//   SCAN:    NSEG cycles. Cycle i tests segment i; nonzero, i>=NECK_SKIP and overlapping sets hit.
//            No early exit, so latency is fixed.
//   FOOD:    eat = overlap(head, food).
//   REPORT:  done=1 for one cycle.
//            If hit: game_over<=1 and grow stays 0 (collision beats food).
//            Else if eat: grow=1 and go to RESPAWN.
//            Else go to IDLE.
//   RESPAWN: candidate x = lfsr[CW-1:0], y = lfsr[2CW-1:CW].
//            Accept if x<=FIELD_W-FOOD_SZ && y<=FIELD_H-FOOD_SZ; then load food and go to IDLE.
//            Otherwise retry next cycle. busy stays 1.
//  Latency: done is high exactly NSEG+4 cycles after the edge that sampled update (9 at defaults).
//  LFSR: 2*CW-bit Fibonacci, maximal-length taps, free-running every cycle from reset. Never 0.
//  update seen while busy=1 or game_over=1 is dropped. There is no queueing.
//  The new food box is not checked against the snake body; overlap is resolved on the next check.
//  Only start_n clears game_over.
// STRUCTURE
//  Shared package (snake_pkg):
//   CW, NSEG, FIELD_W, FIELD_H, box field slice macros, state encoding, overlap function.
//  One sub-module: snake_lfsr (width, taps, seed; outputs the current value).
//  Keep the FSM, capture registers, comparators and food register in this module.
// TESTING
//  1. Reset, no update -> food={320,240,327,247}, grow=game_over=done=busy=0.
//  2. head={100,100,107,107}, body all 0, update -> done at cycle +9, grow=0, game_over=0, busy back to 0.
//  3. head={320,240,327,247} -> done and grow pulse together at +9.
//     Then busy stays high until food is reloaded inside the field; the new food differs from the reset value.
//  4. head={636,10,643,17} -> game_over=1 at +9, grow=0.
//     A further update is ignored: busy stays 0, no done.
//  5. head overlaps seg0 only -> no game_over (neck).
//     head overlaps seg2 and food together -> game_over=1, grow=0.
//  6. update during busy -> ignored, single done. Reset pulse during SCAN -> outputs reset, no done.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake collision checker: box layout {x0,y0,x1,y1}, FSM states, overlap test.
// Pure declarations; no timing and no handshake.
package snake_pkg;

  localparam int CW   = 10;
  localparam int NSEG = 5;

  typedef logic [CW-1:0] coord_t;

  localparam coord_t FIELD_W = CW'(640);
  localparam coord_t FIELD_H = CW'(480);

  // x^20 + x^17 + 1, maximal length for the 2*CW = 20 bit food generator
  localparam logic [2*CW-1:0] LFSR_TAPS = 20'h90000;

  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
  } box_t;

  typedef box_t [NSEG-1:0] body_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WALL,
    ST_SCAN,
    ST_FOOD,
    ST_REPORT,
    ST_RESPAWN
  } state_t;

  function automatic logic overlap(input box_t a, input box_t b);
    return (a.x0 <= b.x1) && (b.x0 <= a.x1) && (a.y0 <= b.y1) && (b.y0 <= a.y1);
  endfunction

  function automatic logic box_unused(input box_t b);
    return b == '0;
  endfunction

  function automatic box_t mk_box(input coord_t x, input coord_t y, input coord_t sz);
    box_t b;
    b.x0 = x;
    b.y0 = y;
    b.x1 = x + sz - coord_t'(1);
    b.y1 = y + sz - coord_t'(1);
    return b;
  endfunction

endpackage

// File: rtl/snake_collide_if.sv
// Snake-to-collision bus: update pulse plus head/body boxes in, verdicts and food box out.
// No backpressure; the checker drops updates it cannot take.
interface snake_collide_if;
  import snake_pkg::*;

  logic  update;
  box_t  head;
  body_t body;
  logic  grow;
  logic  game_over;
  logic  done;
  logic  busy;
  box_t  food;

  modport master (
    output update, head, body,
    input  grow, game_over, done, busy, food
  );

  modport slave (
    input  update, head, body,
    output grow, game_over, done, busy, food
  );

endinterface

// File: rtl/snake_lfsr.sv
// Free-running Fibonacci LFSR; advances every cycle, value is the registered state.
// No handshake; reset loads SEED, which must be nonzero.
module snake_lfsr #(
  parameter int               WIDTH = 20,
  parameter logic [WIDTH-1:0] TAPS  = 20'h90000,
  parameter logic [WIDTH-1:0] SEED  = 20'h00001
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else begin
      value <= {value[WIDTH-2:0], ^(value & TAPS)};
    end
  end

endmodule

// File: rtl/snake_collide.sv
// Checks each new snake head against walls, non-neck body segments and food; respawns food from an LFSR.
// done pulses NSEG+4 cycles after update is sampled; updates during busy or after game_over are dropped.
module snake_collide
  import snake_pkg::*;
#(
  parameter int              NECK_SKIP = 1,
  parameter int              FOOD_SZ   = 8,
  parameter int              FOOD_X0   = 320,
  parameter int              FOOD_Y0   = 240,
  parameter logic [2*CW-1:0] SEED      = 20'h1
) (
  input logic            clk,
  input logic            start_n,
  snake_collide_if.slave bus
);

  localparam int          SW       = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SW-1:0] SEG_LAST = SW'(NSEG - 1);
  localparam logic [SW:0]   SEG_NECK = (SW + 1)'(NECK_SKIP);
  localparam coord_t      SZ       = CW'(FOOD_SZ);
  localparam coord_t      X_MAX    = FIELD_W - SZ;
  localparam coord_t      Y_MAX    = FIELD_H - SZ;
  localparam box_t        FOOD_RST = mk_box(CW'(FOOD_X0), CW'(FOOD_Y0), SZ);

  state_t          state;
  logic [SW-1:0]   seg_idx;
  box_t            head_q;
  body_t           body_q;
  logic            hit;
  logic            eat;
  box_t            food_q;
  logic            grow_q;
  logic            over_q;
  logic            done_q;
  logic            busy_q;
  logic [2*CW-1:0] lfsr;

  snake_lfsr #(
    .WIDTH (2 * CW),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (start_n),
    .value (lfsr)
  );

  coord_t cand_x;
  coord_t cand_y;
  logic   cand_ok;
  logic   wall_hit;
  box_t   seg_box;
  logic   seg_hit;

  always_comb begin
    cand_x   = lfsr[CW-1:0];
    cand_y   = lfsr[2*CW-1:CW];
    cand_ok  = (cand_x <= X_MAX) && (cand_y <= Y_MAX);
    // A wrapped coordinate shows up as an inverted box
    wall_hit = (head_q.x1 >= FIELD_W) || (head_q.y1 >= FIELD_H) ||
               (head_q.x0 > head_q.x1) || (head_q.y0 > head_q.y1);
    seg_box  = body_q[seg_idx];
    seg_hit  = !box_unused(seg_box) && ({1'b0, seg_idx} >= SEG_NECK) && overlap(head_q, seg_box);
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      state   <= ST_IDLE;
      seg_idx <= '0;
      head_q  <= '0;
      body_q  <= '0;
      hit     <= 1'b0;
      eat     <= 1'b0;
      food_q  <= FOOD_RST;
      grow_q  <= 1'b0;
      over_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      grow_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.update && !over_q) begin
            state  <= ST_ARM;
            busy_q <= 1'b1;
          end
        end
        ST_ARM: begin
          head_q  <= bus.head;
          body_q  <= bus.body;
          hit     <= 1'b0;
          eat     <= 1'b0;
          seg_idx <= '0;
          state   <= ST_WALL;
        end
        ST_WALL: begin
          hit   <= wall_hit;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          // Every segment gets its cycle so the verdict latency never varies
          if (seg_hit) hit <= 1'b1;
          if (seg_idx == SEG_LAST) begin
            state <= ST_FOOD;
          end else begin
            seg_idx <= seg_idx + 1'b1;
          end
        end
        ST_FOOD: begin
          eat   <= overlap(head_q, food_q);
          state <= ST_REPORT;
        end
        ST_REPORT: begin
          done_q <= 1'b1;
          if (hit) begin
            over_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else if (eat) begin
            grow_q <= 1'b1;
            state  <= ST_RESPAWN;
          end else begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_RESPAWN: begin
          if (cand_ok) begin
            food_q <= mk_box(cand_x, cand_y, SZ);
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grow      = grow_q;
  assign bus.game_over = over_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.food      = food_q;

endmodule

// File: tb/tb_snake_collide.sv
// Directed bench for snake_collide: a per-cycle scoreboard model plus hand-computed literal checks.
module tb_snake_collide;
  import snake_pkg::*;

  localparam int   LAT      = NSEG + 4;
  localparam int   NECK     = 1;
  localparam box_t FOOD_RST = {10'd320, 10'd240, 10'd327, 10'd247};

  logic clk = 1'b0;
  logic start_n;

  snake_collide_if bus ();

  snake_collide dut (
    .clk     (clk),
    .start_n (start_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic box_t bx(input int x0, input int y0, input int x1, input int y1);
    box_t b;
    b.x0 = CW'(x0);
    b.y0 = CW'(y0);
    b.x1 = CW'(x1);
    b.y1 = CW'(y1);
    return b;
  endfunction

  function automatic bit ovl(input box_t a, input box_t b);
    return int'(a.x0) <= int'(b.x1) && int'(b.x0) <= int'(a.x1) &&
           int'(a.y0) <= int'(b.y1) && int'(b.y0) <= int'(a.y1);
  endfunction

  function automatic bit off_field(input box_t h);
    return int'(h.x1) >= 640 || int'(h.y1) >= 480 || h.x0 > h.x1 || h.y0 > h.y1;
  endfunction

  // Scoreboard: phase of the check in flight, predicted verdict and known food box
  typedef enum {P_IDLE, P_RUN, P_RESP} ph_t;
  ph_t  ph     = P_IDLE;
  int   m_cnt  = 0;
  int   m_resp = 0;
  bit   m_go   = 1'b0;
  bit   m_hit  = 1'b0;
  bit   m_eat  = 1'b0;
  box_t m_food = FOOD_RST;

  always @(posedge clk) begin
    bit    upd, rstv, fin, in_resp, eb, eg;
    box_t  h;
    body_t b;
    upd  = bus.update;
    rstv = start_n;
    h    = bus.head;
    b    = bus.body;
    #1;
    fin     = 1'b0;
    in_resp = (ph == P_RESP);
    if (!rstv) begin
      ph = P_IDLE; m_go = 1'b0; m_food = FOOD_RST; m_cnt = 0; in_resp = 1'b0;
    end else begin
      case (ph)
        P_IDLE: if (upd && !m_go) begin ph = P_RUN; m_cnt = 0; end
        P_RUN: begin
          m_cnt++;
          if (m_cnt == 1) begin
            m_hit = off_field(h);
            for (int i = NECK; i < NSEG; i++)
              if (b[i] != '0 && ovl(h, b[i])) m_hit = 1'b1;
            m_eat = ovl(h, m_food);
          end
          if (m_cnt == LAT) begin
            fin = 1'b1;
            if (m_hit) m_go = 1'b1;
            ph     = (m_eat && !m_hit) ? P_RESP : P_IDLE;
            m_resp = 0;
          end
        end
        P_RESP: begin
          if (bus.food != m_food) begin
            chk("respawn_x_range", int'(bus.food.x0) <= 632, 1'b1);
            chk("respawn_y_range", int'(bus.food.y0) <= 472, 1'b1);
            chk("respawn_x_size", int'(bus.food.x1) - int'(bus.food.x0), 7);
            chk("respawn_y_size", int'(bus.food.y1) - int'(bus.food.y0), 7);
            m_food = bus.food;
            ph     = P_IDLE;
          end else if (++m_resp > 400) begin
            chk("respawn_timeout", 1'b1, 1'b0);
            ph = P_IDLE;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
    eg = fin && m_eat && !m_hit;
    eb = (ph == P_RUN) || (ph == P_RESP);
    chk("done", bus.done, fin);
    chk("grow", bus.grow, eg);
    chk("game_over", bus.game_over, m_go);
    chk("busy", bus.busy, eb);
    if (!in_resp) chk("food", bus.food, m_food);
  end

  task automatic send(input box_t h, input body_t b);
    @(negedge clk);
    bus.head   = h;
    bus.body   = b;
    bus.update = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
  endtask

  task automatic expect_done(input string nm, input bit g, input bit go);
    bit seen;
    int lat;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(posedge clk); #2;
      if (bus.done) begin seen = 1'b1; lat = k; end
    end
    chk({nm, "_latency"}, lat, LAT);
    if (seen) begin
      chk({nm, "_grow"}, bus.grow, g);
      chk({nm, "_game_over"}, bus.game_over, go);
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 500 && bus.busy; k++) begin
      @(posedge clk); #2;
    end
    chk({nm, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic watch(input int n, output int dones, output int busies);
    dones  = 0;
    busies = 0;
    repeat (n) begin
      @(posedge clk); #2;
      if (bus.done) dones++;
      if (bus.busy) busies++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
  endtask

  initial begin
    body_t b;
    int    nd, nb;
    bus.update = 1'b0;
    bus.head   = '0;
    bus.body   = '0;
    start_n    = 1'b0;
    repeat (3) @(negedge clk);
    start_n = 1'b1;
    @(negedge clk);

    chk("rst_food", bus.food, bx(320, 240, 327, 247));
    chk("rst_grow", bus.grow, 1'b0);
    chk("rst_game_over", bus.game_over, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);

    b = '0;
    send(bx(100, 100, 107, 107), b);
    expect_done("plain", 1'b0, 1'b0);
    chk("plain_busy_after", bus.busy, 1'b0);

    send(bx(0, 0, 7, 7), b);
    expect_done("origin_unused_segs", 1'b0, 1'b0);

    send(bx(632, 472, 639, 479), b);
    expect_done("far_corner_inside", 1'b0, 1'b0);

    b    = '0;
    b[0] = bx(104, 104, 111, 111);
    b[1] = bx(200, 200, 207, 207);
    send(bx(100, 100, 107, 107), b);
    expect_done("neck_only", 1'b0, 1'b0);

    // Second update lands in SCAN and must vanish
    b = '0;
    send(bx(50, 60, 57, 67), b);
    repeat (3) @(negedge clk);
    bus.update = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
    watch(25, nd, nb);
    chk("busy_drop_dones", nd, 1);

    send(bx(50, 60, 57, 67), b);
    repeat (2) @(negedge clk);
    start_n = 1'b0;
    #1;
    chk("midreset_busy", bus.busy, 1'b0);
    chk("midreset_done", bus.done, 1'b0);
    chk("midreset_food", bus.food, FOOD_RST);
    @(negedge clk);
    start_n = 1'b1;
    watch(20, nd, nb);
    chk("midreset_no_done", nd, 0);
    chk("midreset_no_busy", nb, 0);

    send(bx(320, 240, 327, 247), b);
    expect_done("eat", 1'b1, 1'b0);
    chk("eat_busy_during_respawn", bus.busy, 1'b1);
    wait_idle("eat");
    chk("eat_food_moved", bus.food != FOOD_RST, 1'b1);

    do_reset();
    chk("reset_restores_food", bus.food, FOOD_RST);
    b    = '0;
    b[0] = bx(330, 240, 337, 247);
    b[2] = bx(324, 244, 331, 251);
    send(bx(320, 240, 327, 247), b);
    expect_done("seg2_and_food", 1'b0, 1'b1);

    do_reset();
    chk("reset_clears_game_over", bus.game_over, 1'b0);
    b = '0;
    send(bx(636, 10, 643, 17), b);
    expect_done("right_wall", 1'b0, 1'b1);
    send(bx(100, 100, 107, 107), b);
    watch(15, nd, nb);
    chk("over_no_done", nd, 0);
    chk("over_no_busy", nb, 0);
    chk("over_sticky", bus.game_over, 1'b1);

    do_reset();
    send(bx(10, 10, 5, 17), b);
    expect_done("wrapped_x", 1'b0, 1'b1);

    do_reset();
    send(bx(100, 475, 107, 482), b);
    expect_done("bottom_wall", 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
